// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives the request, slave returns the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output A,
        output B,
        input  Diff,
        input  Borrow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output Diff,
        output Borrow,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B mod 2^WIDTH, LSB first,
// one full-subtractor cell plus a borrow flop, start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bor;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic             d;
    logic             bor_nx;
    logic             accept;
    logic             last;

    // Single full-subtractor cell on the current LSBs.
    always_comb begin
        d      = ra[0] ^ rb[0] ^ bor;
        bor_nx = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bor);
        accept = (state == S_IDLE) && bus.start;
        last   = (state == S_SHIFT) && (cnt == LAST);
    end

    // Sequencer: idle -> shift WIDTH bits -> one done cycle -> idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand shifters, borrow bit, bit counter and result shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            res <= '0;
            cnt <= '0;
            bor <= 1'b0;
        end else if (accept) begin
            ra  <= bus.A;
            rb  <= bus.B;
            res <= '0;
            cnt <= '0;
            bor <= 1'b0;
        end else if (state == S_SHIFT) begin
            ra  <= {1'b0, ra[WIDTH-1:1]};
            rb  <= {1'b0, rb[WIDTH-1:1]};
            res <= {d, res[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            bor <= bor_nx;
        end
    end

    // Result registers only move on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (last) begin
            diff_q   <= {d, res[WIDTH-1:1]};
            borrow_q <= bor_nx;
        end
    end

    // Registered status flags; busy and done are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= accept || ((state == S_SHIFT) && !last);
            done_q <= last;
        end
    end

    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
